// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the F/D, D/X, X/M, M/W latches and the PC: load-use
// bubbles, taken-branch squashes and the multicycle mult/div freeze.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 48,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fdRs,
  input  logic [4:0]       fdRt,
  input  logic             fdUsesRs,
  input  logic             fdUsesRt,
  input  logic [4:0]       dxRd,
  input  logic             dxLw,
  input  logic             dxMultDiv,
  input  logic             branchTaken,
  input  logic             mdReady,
  output logic             pcEnable,
  output logic             fdEnable,
  output logic             dxEnable,
  output logic             xmEnable,
  output logic             mwEnable,
  output logic             fdFlush,
  output logic             dxFlush,
  output logic             xmFlush,
  output logic             mdStart,
  output logic             mdSelect,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [1:0]       dbgState
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } stateT;

  stateT         state, nextState;
  logic [TW-1:0] waitCount;
  logic          loadUse;
  logic          waitExpired;

  assign dbgState = state;

  assign loadUse = dxLw && (dxRd != 5'd0) &&
                   ((fdUsesRs && (fdRs == dxRd)) || (fdUsesRt && (fdRt == dxRd)));
  assign waitExpired = (waitCount == LAST_WAIT);

  // Handshake: mdStart is a one-cycle request issued on entry to MD_START;
  // mdReady is a level from the unit and is only honoured in MD_WAIT, so a
  // ready left over from the previous op can never complete the next one.
  always_comb begin
    pcEnable  = 1'b0;
    fdEnable  = 1'b0;
    dxEnable  = 1'b0;
    xmEnable  = 1'b0;
    mwEnable  = 1'b0;
    fdFlush   = 1'b0;
    dxFlush   = 1'b0;
    xmFlush   = 1'b0;
    mdSelect  = 1'b0;
    nextState = state;
    if (reset) begin
      case (state)
        RUN: begin
          pcEnable = 1'b1;
          fdEnable = 1'b1;
          dxEnable = 1'b1;
          xmEnable = 1'b1;
          mwEnable = 1'b1;
          if (branchTaken) begin
            fdFlush = 1'b1;
            dxFlush = 1'b1;
          end else if (dxMultDiv) begin
            pcEnable  = 1'b0;
            fdEnable  = 1'b0;
            dxEnable  = 1'b0;
            xmFlush   = 1'b1;
            nextState = MD_START;
          end else if (loadUse) begin
            pcEnable = 1'b0;
            fdEnable = 1'b0;
            dxFlush  = 1'b1;
          end
        end
        MD_START, MD_WAIT: begin
          // Front end held; X/M fills with NOPs while M/W drains.
          xmEnable = 1'b1;
          mwEnable = 1'b1;
          xmFlush  = 1'b1;
          if (state == MD_START) begin
            nextState = MD_WAIT;
          end else if (mdReady || waitExpired) begin
            nextState = MD_DONE;
          end
        end
        MD_DONE: begin
          pcEnable  = 1'b1;
          fdEnable  = 1'b1;
          dxEnable  = 1'b1;
          xmEnable  = 1'b1;
          mwEnable  = 1'b1;
          mdSelect  = 1'b1;
          nextState = RUN;
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      waitCount  <= '0;
      mdStart    <= 1'b0;
      mdTimeout  <= 1'b0;
      stallCount <= '0;
    end else begin
      state   <= nextState;
      mdStart <= (state == RUN) && (nextState == MD_START);
      if (state == MD_START) begin
        waitCount <= '0;
      end else if (state == MD_WAIT) begin
        waitCount <= waitCount + TW'(1);
      end
      if ((state == MD_WAIT) && !mdReady && waitExpired) begin
        mdTimeout <= 1'b1;
      end
      if (!pcEnable && (stallCount != {CNT_W{1'b1}})) begin
        stallCount <= stallCount + CNT_W'(1);
      end
    end
  end

endmodule
